multicycle_ctrl: RTL
====================

# multicycle_ctrl

- Control sequencer for the multi-cycle MIPS datapath.
- Takes the one-hot instruction decode plus ALU status flags and steps each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Emits per-cycle write enables and mux selects for PC, IR, GRF and DM, and handshakes with instruction and data memory.
- Counts retired instructions.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `addu, subu, ori, lw, sw, beq, bgezal, lui, jal, jr, j` in 1 each: one-hot opcode decode of the current IR.
- `zero` in 1: ALU equality flag (rs == rt).
- `ge0` in 1: rs[31] == 0.
- `im_ready` in 1: instruction memory returns data this cycle.
- `dm_ready` in 1: data memory completes the access this cycle.
- `im_req` out 1: instruction fetch request.
- `dm_req` out 1: data access request.
- `dm_write` out 1: data access is a store.
- `ir_write` out 1: latch IR.
- `pc_write` out 1: update PC.
- `pc_src` out 2: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = register rs.
- `ab_write` out 1: latch GRF read ports into A/B.
- `alu_src` out 1: 1 = immediate operand.
- `aluc` out 3: ALU op. 010 = add, 110 = sub, 001 = or/lui path.
- `aluout_write` out 1: latch ALUOut.
- `mdr_write` out 1: latch memory data register.
- `grf_write` out 1: register file write enable.
- `grf_dst` out 2: 0 = rt, 1 = rd, 2 = $31.
- `grf_src` out 2: 0 = ALUOut, 1 = MDR, 2 = PC (link), 3 = lui immediate.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: one-cycle pulse in DECODE when no opcode is hot.
- `retired` out 32: retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP.
- FETCH: `im_req` = 1. On `im_ready`: `ir_write` = 1, `pc_write` = 1, `pc_src` = 0, next state DECODE. Otherwise stay.
- DECODE: `ab_write` = 1. Next state by opcode priority jr > j > jal > beq > bgezal > lw > sw > addu > subu > ori > lui:
  - jr/j/jal → JUMP.
  - beq/bgezal → BRANCH.
  - lw/sw → MEMADR.
  - addu/subu/ori/lui → EXEC.
  - none hot → `illegal` pulse, next state FETCH. The illegal instruction is not counted.
- EXEC: `aluout_write` = 1. `aluc`: addu 010, subu 110, ori/lui 001. `alu_src` = ori|lui. Next state ALUWB.
- ALUWB: `grf_write` = 1. `grf_dst` = 1 for addu/subu, else 0. `grf_src` = 3 for lui, else 0. Retire. Next state FETCH.
- MEMADR: `aluc` = 010, `alu_src` = 1, `aluout_write` = 1. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: `dm_req` = 1. On `dm_ready`: `mdr_write` = 1, next state MEMWB.
- MEMWB: `grf_write` = 1, `grf_dst` = 0, `grf_src` = 1. Retire. Next state FETCH.
- MEMWR: `dm_req` = `dm_write` = 1. On `dm_ready`: retire, next state FETCH.
- BRANCH: `aluc` = 110. `pc_src` = 1.
  - beq: `pc_write` = `zero`.
  - bgezal: `pc_write` = `ge0`. Also `grf_write` = 1 with `grf_dst` = 2, `grf_src` = 2, unconditionally.
  - Retire. Next state FETCH.
- JUMP:
  - `pc_write` = 1.
  - `pc_src` = 3 for jr, else 2.
  - jal: `grf_write` = 1, `grf_dst` = 2, `grf_src` = 2.
  - Retire. Next state FETCH.
- Retire means `instr_done` = 1 and `retired` += 1. `retired` wraps from 0xFFFFFFFF to 0.
- Unlisted outputs are 0 in every state.
- The opcode inputs are only sampled in DECODE and in the states after it. They are stable because IR is only written in FETCH.

## Timing
- Outputs are Moore-style from the state register, plus opcode/flag/ready qualification from the current cycle.
- Minimum latency with zero wait states:
  - ALU ops: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch/jump: 3 cycles.
- Each memory wait cycle adds exactly 1 cycle. `dm_req` stays high, and `dm_write` holds its value, until `dm_ready` is seen.
- `ready` is ignored outside its requesting state.
- `instr_done` is asserted in the same cycle as the final architectural write.
- Reset while `reset` = 0:
  - state = FETCH.
  - `retired` = 0.
  - All outputs 0, including `im_req`.
  - Takes effect immediately, even mid-access.
- First `im_req` is asserted in the first cycle after reset deasserts. Deassertion is synchronised externally.

## Configuration
- `MULTICYCLE_MEM_WAIT_EN` defined: FETCH, MEMRD and MEMWR wait on `im_ready`/`dm_ready` as above.
- `MULTICYCLE_MEM_WAIT_EN` undefined: both ready inputs are treated as constant 1, so every memory state lasts exactly one cycle. The ports remain present but unused.

## Structure
- Shared package `multicycle_pkg`:
  - State enumeration, 4-bit encoding.
  - `pc_src` constants: PC_PC4, PC_BR, PC_JMP, PC_REG.
  - `grf_dst` constants: DST_RT, DST_RD, DST_RA.
  - `grf_src` constants: SRC_ALU, SRC_MDR, SRC_PC, SRC_LUI.
  - ALU op codes: ALU_ADD, ALU_SUB, ALU_OR.
- One sub-module, `multicycle_outdec`: combinational decode from state + opcode + flags + ready to all output enables/selects.
- The top level holds the state register, the next-state logic and the `retired` counter.

## Test plan
- Reset asserted mid-MEMRD with `dm_req` = 1 → all outputs 0 that cycle; after release, `im_req` = 1 and `retired` = 0.
- addu, zero wait states → `grf_write` = 1 with `grf_dst` = 1 exactly 4 cycles after FETCH entry; `retired` goes 0→1.
- lw with `dm_ready` held low 3 cycles (MEM_WAIT_EN) → `dm_req` stays high 4 cycles; `mdr_write` in the 4th; `grf_src` = 1 next cycle; total 8 cycles.
- beq with `zero` = 0, then beq with `zero` = 1 → `pc_write` 0 then 1 in BRANCH, `pc_src` = 1; each retires in 3 cycles.
- bgezal with `ge0` = 0 → `pc_write` = 0, `grf_write` = 1, `grf_dst` = 2, `grf_src` = 2; jr → `pc_src` = 3, `grf_write` = 0.
- No opcode hot in DECODE → `illegal` pulse, return to FETCH, `retired` unchanged; `retired` preloaded to 0xFFFFFFFF plus one sw → wraps to 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// ============================================================================
//  multicycle_pkg
//  Shared state encoding, datapath select codes and opcode bundle for the
//  multi-cycle MIPS control sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package multicycle_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_ALUWB  = 4'd3,
        ST_MEMADR = 4'd4,
        ST_MEMRD  = 4'd5,
        ST_MEMWB  = 4'd6,
        ST_MEMWR  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9
    } state_t;

    localparam logic [1:0] PC_PC4  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_JMP  = 2'd2;
    localparam logic [1:0] PC_REG  = 2'd3;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_RA  = 2'd2;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MDR = 2'd1;
    localparam logic [1:0] SRC_PC  = 2'd2;
    localparam logic [1:0] SRC_LUI = 2'd3;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_OR  = 3'b001;

    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic bgezal;
        logic lui;
        logic jal;
        logic jr;
        logic j;
    } op_t;

    // State following DECODE; jumps win over branches over memory over ALU ops.
    function automatic state_t decode_next(input op_t op);
        if (op.jr || op.j || op.jal)
            return ST_JUMP;
        else if (op.beq || op.bgezal)
            return ST_BRANCH;
        else if (op.lw || op.sw)
            return ST_MEMADR;
        else if (op.addu || op.subu || op.ori || op.lui)
            return ST_EXEC;
        else
            return ST_FETCH;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_outdec.sv
// ============================================================================
//  multicycle_outdec
//  Combinational decode of state, opcode, ALU flags and memory ready into
//  every datapath enable and select.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_outdec
    import multicycle_pkg::*;
(
    input  logic       en,
    input  state_t     state,
    input  op_t        op,
    input  logic       zero,
    input  logic       ge0,
    input  logic       im_rdy,
    input  logic       dm_rdy,
    output logic       im_req,
    output logic       dm_req,
    output logic       dm_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ab_write,
    output logic       alu_src,
    output logic [2:0] aluc,
    output logic       aluout_write,
    output logic       mdr_write,
    output logic       grf_write,
    output logic [1:0] grf_dst,
    output logic [1:0] grf_src,
    output logic       instr_done,
    output logic       illegal
);

    always_comb begin
        im_req       = 1'b0;
        dm_req       = 1'b0;
        dm_write     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PC4;
        ab_write     = 1'b0;
        alu_src      = 1'b0;
        aluc         = 3'b000;
        aluout_write = 1'b0;
        mdr_write    = 1'b0;
        grf_write    = 1'b0;
        grf_dst      = DST_RT;
        grf_src      = SRC_ALU;
        instr_done   = 1'b0;
        illegal      = 1'b0;

        // en low holds every output at zero while reset is asserted
        if (en) begin
            case (state)
                ST_FETCH: begin
                    im_req = 1'b1;
                    if (im_rdy) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_DECODE: begin
                    ab_write = 1'b1;
                    illegal  = ~|op;
                end
                ST_EXEC: begin
                    aluout_write = 1'b1;
                    alu_src      = op.ori | op.lui;
                    if (op.addu)
                        aluc = ALU_ADD;
                    else if (op.subu)
                        aluc = ALU_SUB;
                    else
                        aluc = ALU_OR;
                end
                ST_ALUWB: begin
                    grf_write  = 1'b1;
                    grf_dst    = (op.addu | op.subu) ? DST_RD : DST_RT;
                    grf_src    = op.lui ? SRC_LUI : SRC_ALU;
                    instr_done = 1'b1;
                end
                ST_MEMADR: begin
                    aluc         = ALU_ADD;
                    alu_src      = 1'b1;
                    aluout_write = 1'b1;
                end
                ST_MEMRD: begin
                    dm_req    = 1'b1;
                    mdr_write = dm_rdy;
                end
                ST_MEMWB: begin
                    grf_write  = 1'b1;
                    grf_src    = SRC_MDR;
                    instr_done = 1'b1;
                end
                ST_MEMWR: begin
                    dm_req     = 1'b1;
                    dm_write   = 1'b1;
                    instr_done = dm_rdy;
                end
                ST_BRANCH: begin
                    aluc       = ALU_SUB;
                    pc_src     = PC_BR;
                    instr_done = 1'b1;
                    if (op.beq) begin
                        pc_write = zero;
                    end else begin
                        pc_write  = ge0;
                        grf_write = 1'b1;
                        grf_dst   = DST_RA;
                        grf_src   = SRC_PC;
                    end
                end
                ST_JUMP: begin
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    if (op.jr) begin
                        pc_src = PC_REG;
                    end else begin
                        pc_src = PC_JMP;
                        if (!op.j && op.jal) begin
                            grf_write = 1'b1;
                            grf_dst   = DST_RA;
                            grf_src   = SRC_PC;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  multicycle_ctrl
//  Multi-cycle MIPS control sequencer: state register, next-state logic and
//  retired-instruction counter. Macro MULTICYCLE_MEM_WAIT_EN enables memory
//  wait states on im_ready/dm_ready.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        addu,
    input  logic        subu,
    input  logic        ori,
    input  logic        lw,
    input  logic        sw,
    input  logic        beq,
    input  logic        bgezal,
    input  logic        lui,
    input  logic        jal,
    input  logic        jr,
    input  logic        j,
    input  logic        zero,
    input  logic        ge0,
    input  logic        im_ready,
    input  logic        dm_ready,
    output logic        im_req,
    output logic        dm_req,
    output logic        dm_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ab_write,
    output logic        alu_src,
    output logic [2:0]  aluc,
    output logic        aluout_write,
    output logic        mdr_write,
    output logic        grf_write,
    output logic [1:0]  grf_dst,
    output logic [1:0]  grf_src,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] retired
);

    state_t      r_state;
    state_t      w_next;
    op_t         w_op;
    logic        w_im_rdy;
    logic        w_dm_rdy;
    logic [31:0] r_retired;

    assign w_op = '{addu: addu, subu: subu, ori: ori, lw: lw, sw: sw,
                    beq: beq, bgezal: bgezal, lui: lui, jal: jal, jr: jr, j: j};

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign w_im_rdy = im_ready;
    assign w_dm_rdy = dm_ready;
`else
    // Zero-wait memories: ready ports are kept for pin compatibility only
    logic w_unused_ready;
    assign w_unused_ready = im_ready ^ dm_ready;
    assign w_im_rdy       = 1'b1;
    assign w_dm_rdy       = 1'b1;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  if (w_im_rdy) w_next = ST_DECODE;
            ST_DECODE: w_next = decode_next(w_op);
            ST_EXEC:   w_next = ST_ALUWB;
            ST_ALUWB:  w_next = ST_FETCH;
            ST_MEMADR: w_next = w_op.lw ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (w_dm_rdy) w_next = ST_MEMWB;
            ST_MEMWB:  w_next = ST_FETCH;
            ST_MEMWR:  if (w_dm_rdy) w_next = ST_FETCH;
            ST_BRANCH: w_next = ST_FETCH;
            ST_JUMP:   w_next = ST_FETCH;
            default:   w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_FETCH;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_retired <= 32'd0;
        else if (instr_done)
            r_retired <= r_retired + 32'd1;
    end

    assign retired = r_retired;

    multicycle_outdec u_outdec (
        .en           (reset),
        .state        (r_state),
        .op           (w_op),
        .zero         (zero),
        .ge0          (ge0),
        .im_rdy       (w_im_rdy),
        .dm_rdy       (w_dm_rdy),
        .im_req       (im_req),
        .dm_req       (dm_req),
        .dm_write     (dm_write),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .ab_write     (ab_write),
        .alu_src      (alu_src),
        .aluc         (aluc),
        .aluout_write (aluout_write),
        .mdr_write    (mdr_write),
        .grf_write    (grf_write),
        .grf_dst      (grf_dst),
        .grf_src      (grf_src),
        .instr_done   (instr_done),
        .illegal      (illegal)
    );

endmodule

`default_nettype wire
